// File: rtl/mdr_mem_interface.sv
// MAR/MDR holder running single-word read/write handshakes with external memory.
// Optional ack timeout with sticky mem_err is enabled by defining MEM_TIMEOUT_EN.
module mdr_mem_interface #(
  parameter int ADDR_W = 9
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [31:0]       BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       BusMuxIn_MDR,
  output logic              busy,
  output logic              done,
  output logic              mem_err
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_mar;
  logic [31:0]         r_mdr;
  logic                w_active;
  logic                w_timeout;

  assign w_active = (r_state == S_RD) || (r_state == S_WR);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  assign w_timeout = w_active && !mem_ack && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter is held at 0 while idle so every transaction starts counting from 0.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_active && !mem_ack)
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;
      if (r_state == S_IDLE && (MemRead || MemWrite))
        r_err <= 1'b0;
      else if (w_timeout)
        r_err <= 1'b1;
    end
  end

  assign mem_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign mem_err   = 1'b0;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (MemRead)
          w_next_state = S_RD;
        else if (MemWrite)
          w_next_state = S_WR;
      end
      S_RD, S_WR: begin
        if (mem_ack || w_timeout)
          w_next_state = S_DONE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      S_RD:    begin mem_req = 1'b1; busy = 1'b1; end
      S_WR:    begin mem_req = 1'b1; busy = 1'b1; mem_we = 1'b1; end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Bus loads are only honoured in IDLE so address/data stay stable during a handshake.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_mar <= '0;
      r_mdr <= '0;
    end else if (r_state == S_IDLE) begin
      if (MARin)
        r_mar <= BusMuxOut[ADDR_W-1:0];
      if (MDRin)
        r_mdr <= BusMuxOut;
    end else if (r_state == S_RD) begin
      if (mem_ack)
        r_mdr <= mem_rdata;
      else if (w_timeout)
        r_mdr <= 32'hDEAD_BEEF;
    end
  end

  assign mem_addr     = r_mar;
  assign mem_wdata    = r_mdr;
  assign BusMuxIn_MDR = r_mdr;

endmodule

// File: tb/tb_mdr_mem_interface.sv
// Directed bench for mdr_mem_interface with a scoreboard of expected transactions.
module tb_mdr_mem_interface;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] BusMuxOut;
  logic        MARin, MDRin, MemRead, MemWrite;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] BusMuxIn_MDR;
  logic        busy, done, mem_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] mdr;
  } exp_t;

  exp_t sb[$];

  mdr_mem_interface dut (
    .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut),
    .MARin(MARin), .MDRin(MDRin), .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .BusMuxIn_MDR(BusMuxIn_MDR),
    .busy(busy), .done(done), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    MARin = 0; MDRin = 0; MemRead = 0; MemWrite = 0; mem_ack = 0;
  endtask

  // Serve the transaction at the head of the scoreboard: ack after d request cycles.
  task automatic service(input int d, input logic [31:0] rdata, input logic noise);
    exp_t e;
    int   n;
    e = sb[0];
    for (int i = 0; i < d; i++) begin
      chk("req_high", {31'd0, mem_req}, 32'd1);
      chk("req_we", {31'd0, mem_we}, {31'd0, e.we});
      chk("req_addr", {23'd0, mem_addr}, {23'd0, e.addr});
      chk("req_wdata", mem_wdata, e.wdata);
      if (noise) begin
        MARin = 1; MDRin = 1; MemRead = 1; MemWrite = 1; BusMuxOut = 32'h0000_01FF;
      end
      if (i == d - 1) begin
        mem_ack = 1; mem_rdata = rdata;
      end
      @(negedge clock);
    end
    idle_inputs();
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    e = sb.pop_front();
    chk("done_mdr", BusMuxIn_MDR, e.mdr);
    chk("done_req_low", {30'd0, mem_req, busy}, 32'd0);
    $display("txn we=%0d addr=%h mdr=%h", e.we, mem_addr, BusMuxIn_MDR);
    @(negedge clock);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    exp_t e;
    // Reset with random inputs
    clear = 1;
    BusMuxOut = $urandom; MARin = 1'($urandom_range(0, 1)); MDRin = 1'($urandom_range(0, 1));
    MemRead = 1'($urandom_range(0, 1)); MemWrite = 1'($urandom_range(0, 1));
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    repeat (3) @(negedge clock);
    chk("rst_addr", {23'd0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_mdr", BusMuxIn_MDR, 32'd0);
    chk("rst_flags", {27'd0, mem_req, mem_we, busy, done, mem_err}, 32'd0);
    idle_inputs();
    clear = 0;
    @(negedge clock);
    chk("post_rst_busy", {30'd0, busy, mem_req}, 32'd0);

    // Read: load MAR, start, ack two cycles later
    BusMuxOut = 32'h0000_0085; MARin = 1;
    @(negedge clock);
    MARin = 0; MemRead = 1;
    e = '{we: 1'b0, addr: 9'h085, wdata: 32'd0, mdr: 32'h1234_5678};
    sb.push_back(e);
    @(negedge clock);
    idle_inputs();
    service(2, 32'h1234_5678, 1'b0);

    // Write: MDRin, then MARin together with MemWrite (new MAR used)
    BusMuxOut = 32'hCAFE_0001; MDRin = 1;
    @(negedge clock);
    MDRin = 0; BusMuxOut = 32'h0000_0010; MARin = 1; MemWrite = 1;
    e = '{we: 1'b1, addr: 9'h010, wdata: 32'hCAFE_0001, mdr: 32'hCAFE_0001};
    sb.push_back(e);
    @(negedge clock);
    idle_inputs();
    service(3, 32'hFFFF_FFFF, 1'b0);

    // Conflict: read and write together -> read; loads while busy ignored
    BusMuxOut = 32'h0000_01A5; MARin = 1; MemRead = 1; MemWrite = 1;
    e = '{we: 1'b0, addr: 9'h1A5, wdata: 32'hCAFE_0001, mdr: 32'h0BAD_F00D};
    sb.push_back(e);
    @(negedge clock);
    idle_inputs();
    service(3, 32'h0BAD_F00D, 1'b1);
    chk("busy_load_ignored", {23'd0, mem_addr}, 32'h0000_01A5);

    // Minimum latency write
    MemWrite = 1;
    e = '{we: 1'b1, addr: 9'h1A5, wdata: 32'h0BAD_F00D, mdr: 32'h0BAD_F00D};
    sb.push_back(e);
    @(negedge clock);
    idle_inputs();
    service(1, 32'h5555_5555, 1'b0);

    // Ack while idle is ignored
    mem_ack = 1; mem_rdata = 32'h7777_7777;
    @(negedge clock);
    mem_ack = 0;
    @(negedge clock);
    chk("idle_ack_mdr", BusMuxIn_MDR, 32'h0BAD_F00D);
    chk("idle_ack_done", {31'd0, done}, 32'd0);

`ifdef MEM_TIMEOUT_EN
    begin
      int nb;
      BusMuxOut = 32'h0000_0044; MARin = 1; MemRead = 1;
      @(negedge clock);
      idle_inputs();
      nb = 0;
      while (done !== 1'b1 && nb < 40) begin
        if (busy === 1'b1) nb++;
        @(negedge clock);
      end
      chk("to_busy_cycles", nb, 32'd16);
      chk("to_done", {31'd0, done}, 32'd1);
      chk("to_err", {31'd0, mem_err}, 32'd1);
      chk("to_mdr", BusMuxIn_MDR, 32'hDEAD_BEEF);
      $display("timeout busy_cycles=%0d mdr=%h", nb, BusMuxIn_MDR);
      @(negedge clock);
      MemWrite = 1;
      @(negedge clock);
      idle_inputs();
      chk("to_err_cleared", {31'd0, mem_err}, 32'd0);
      mem_ack = 1;
      @(negedge clock);
      mem_ack = 0;
      @(negedge clock);
    end
`endif

    // Clear mid-read drops mem_req immediately
    BusMuxOut = 32'h0000_0033; MARin = 1; MemRead = 1;
    @(negedge clock);
    idle_inputs();
    chk("abort_req_before", {31'd0, mem_req}, 32'd1);
    #2 clear = 1;
    #1;
    chk("abort_req_low", {31'd0, mem_req}, 32'd0);
    chk("abort_mdr", BusMuxIn_MDR, 32'd0);
    chk("abort_addr", {23'd0, mem_addr}, 32'd0);
    $display("abort req=%0d mdr=%h", mem_req, BusMuxIn_MDR);
    @(negedge clock);
    clear = 0;
    @(negedge clock);
    chk("abort_idle", {30'd0, busy, done}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
